// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: 4-word lines, refilled one word at a time from memory.
// Latency: hit completes in the request cycle; miss completes one cycle after the last memory word.
// Backpressure: stall holds fetch during a fill; mem_rd is held until each mem_rdy; no request is taken in RESP.
module icache_ctrl #(
    parameter int INDEX_BITS     = 5,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic        cache_req,
    output logic        cache_hit,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_rdy,
    output logic [15:0] hit_count,
    output logic [15:0] req_count
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int OFF_BITS = $clog2(WORDS_PER_LINE);
    localparam int TAG_BITS = 16 - 1 - OFF_BITS - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

    state_t                state_q, state_d;
    logic [OFF_BITS-1:0]   word_cnt_q, word_cnt_d;
    logic [TAG_BITS-1:0]   tag_lat_q, tag_lat_d;
    logic [INDEX_BITS-1:0] idx_lat_q, idx_lat_d;
    logic [OFF_BITS-1:0]   off_lat_q, off_lat_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic                  flush_pend_q, flush_pend_d;
    logic [15:0]           hit_count_q, hit_count_d;
    logic [15:0]           req_count_q, req_count_d;

    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [15:0]           data_arr [LINES][WORDS_PER_LINE];

    logic [OFF_BITS-1:0]   req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  req_ok;
    logic                  lookup_hit;
    logic                  fill_last;

    assign req_off    = addr[OFF_BITS:1];
    assign req_idx    = addr[OFF_BITS+INDEX_BITS:OFF_BITS+1];
    assign req_tag    = addr[15:16-TAG_BITS];
    assign req_ok     = req && !addr[0];
    assign lookup_hit = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
    assign fill_last  = (state_q == FILL) && mem_rdy &&
                        (word_cnt_q == OFF_BITS'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_ok && !lookup_hit) state_d = FILL;
            FILL:    if (fill_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instr     = '0;
        done      = 1'b0;
        stall     = 1'b0;
        err       = 1'b0;
        cache_req = 1'b0;
        cache_hit = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                if (req && addr[0]) begin
                    done = 1'b1;
                    err  = 1'b1;
                end else if (req_ok) begin
                    cache_req = 1'b1;
                    if (lookup_hit) begin
                        done      = 1'b1;
                        cache_hit = 1'b1;
                        instr     = data_arr[req_idx][req_off];
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {tag_lat_q, idx_lat_q, word_cnt_q, 1'b0};
            end
            RESP: begin
                done  = 1'b1;
                instr = data_arr[idx_lat_q][off_lat_q];
            end
            default: ;
        endcase
    end

    // A flush seen outside IDLE is deferred so the line being filled is invalidated too.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        tag_lat_d    = tag_lat_q;
        idx_lat_d    = idx_lat_q;
        off_lat_d    = off_lat_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        case (state_q)
            IDLE: begin
                if (req_ok && !lookup_hit) begin
                    word_cnt_d = '0;
                    tag_lat_d  = req_tag;
                    idx_lat_d  = req_idx;
                    off_lat_d  = req_off;
                end
                if (flush) valid_d = '0;
            end
            FILL: begin
                if (flush) flush_pend_d = 1'b1;
                if (mem_rdy) word_cnt_d = word_cnt_q + OFF_BITS'(1);
                if (fill_last) valid_d[idx_lat_q] = 1'b1;
            end
            RESP: begin
                if (flush_pend_q || flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        hit_count_d = hit_count_q;
        req_count_d = req_count_q;
        if (cache_hit && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
        if (cache_req && (req_count_q != 16'hFFFF)) req_count_d = req_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q   <= '0;
            tag_lat_q    <= '0;
            idx_lat_q    <= '0;
            off_lat_q    <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            hit_count_q  <= '0;
            req_count_q  <= '0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            tag_lat_q    <= tag_lat_d;
            idx_lat_q    <= idx_lat_d;
            off_lat_q    <= off_lat_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            hit_count_q  <= hit_count_d;
            req_count_q  <= req_count_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if ((state_q == FILL) && mem_rdy) data_arr[idx_lat_q][word_cnt_q] <= mem_data;
        if (fill_last) tag_arr[idx_lat_q] <= tag_lat_q;
    end

    assign hit_count = hit_count_q;
    assign req_count = req_count_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: scoreboarded fetch responses and memory word addresses against a small tag model.
module tb_icache_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [15:0] addr;
    logic        flush;
    logic [15:0] instr;
    logic        done;
    logic        stall;
    logic        err;
    logic        cache_req;
    logic        cache_hit;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_rdy;
    logic [15:0] hit_count;
    logic [15:0] req_count;

    icache_ctrl #(.INDEX_BITS(5), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
        .instr(instr), .done(done), .stall(stall), .err(err),
        .cache_req(cache_req), .cache_hit(cache_hit),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdy(mem_rdy),
        .hit_count(hit_count), .req_count(req_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic        err;
        logic        hit;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] maddr_q[$];
    bit          m_valid[32];
    logic [7:0]  m_tag[32];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          words_seen = 0;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return 16'hA000 + ((a - 16'h0100) >> 1);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    endfunction

    // Memory: ready the cycle after it sees mem_rd; data follows the current word address.
    initial begin : mem_model
        logic        rd_s;
        logic [15:0] ea;
        mem_rdy  = 1'b0;
        mem_data = 16'h0;
        forever begin
            @(negedge clk);
            rd_s = mem_rd;
            if (mem_rd && mem_rdy) begin
                words_seen++;
                n_tests++;
                if (maddr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL mem_addr: unexpected word read at %h, none expected", mem_addr);
                end else begin
                    ea = maddr_q.pop_front();
                    if (mem_addr !== ea) begin
                        n_fail++;
                        $display("FAIL mem_addr: got %h expected %h", mem_addr, ea);
                    end
                end
            end
            @(posedge clk);
            #1;
            mem_rdy  = rd_s;
            mem_data = mem_val(mem_addr);
        end
    end

    task automatic do_req(input logic [15:0] a, input int flush_cyc);
        logic [4:0] idx;
        logic [7:0] tg;
        bit         mis;
        bit         hit;
        bit         got;
        exp_t       e;
        int         c;
        idx = a[7:3];
        tg  = a[15:8];
        mis = a[0];
        hit = !mis && m_valid[idx] && (m_tag[idx] == tg);
        e.instr = mis ? 16'h0 : mem_val(a);
        e.err   = mis;
        e.hit   = hit;
        sb_q.push_back(e);
        if (!mis && !hit)
            for (int w = 0; w < 4; w++) maddr_q.push_back({a[15:3], 2'(w), 1'b0});
        if (!mis) begin
            if (flush_cyc == 0) model_clear();
            if (!hit) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
            end
            if (flush_cyc > 0 && !hit) model_clear();
        end
        req  = 1'b1;
        addr = a;
        c    = 0;
        got  = 1'b0;
        while (!got && c <= 40) begin
            flush = (c == flush_cyc);
            @(negedge clk);
            if (c == 0) begin
                n_tests++;
                if (cache_req !== !mis) begin
                    n_fail++;
                    $display("FAIL cache_req %h: got %b expected %b", a, cache_req, !mis);
                end
                n_tests++;
                if (stall !== (!mis && !hit)) begin
                    n_fail++;
                    $display("FAIL stall %h: got %b expected %b", a, stall, !mis && !hit);
                end
                n_tests++;
                if (mem_rd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mem_rd_req_cycle %h: got %b expected 0", a, mem_rd);
                end
            end
            if (done) begin
                got = 1'b1;
                e = sb_q.pop_front();
                n_tests++;
                if (instr !== e.instr) begin
                    n_fail++;
                    $display("FAIL instr %h: got %h expected %h", a, instr, e.instr);
                end
                n_tests++;
                if (err !== e.err) begin
                    n_fail++;
                    $display("FAIL err %h: got %b expected %b", a, err, e.err);
                end
                n_tests++;
                if (cache_hit !== e.hit) begin
                    n_fail++;
                    $display("FAIL cache_hit %h: got %b expected %b", a, cache_hit, e.hit);
                end
                n_tests++;
                if (c != ((mis || hit) ? 0 : 6)) begin
                    n_fail++;
                    $display("FAIL latency %h: got %0d expected %0d", a, c, (mis || hit) ? 0 : 6);
                end
            end
            @(posedge clk);
            #1;
            c++;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %h: no done after %0d cycles, expected done", a, c);
            sb_q.delete();
            maddr_q.delete();
        end
        req   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req   = 1'b0;
        addr  = 16'h0;
        flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({done, stall, err, cache_req, cache_hit, mem_rd} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {done, stall, err, cache_req, cache_hit, mem_rd});
        end
        n_tests++;
        if (mem_addr !== 16'h0 || instr !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_buses: got mem_addr=%h instr=%h expected 0", mem_addr, instr);
        end
        n_tests++;
        if (hit_count !== 16'h0 || req_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counts: got %h/%h expected 0/0", hit_count, req_count);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_miss_and_hit();
        do_req(16'h0104, -1);
        do_req(16'h0106, -1);
        n_tests++;
        if (hit_count !== 16'd1 || req_count !== 16'd2) begin
            n_fail++;
            $display("FAIL counts_after_hit: got %0d/%0d expected 1/2", hit_count, req_count);
        end
    endtask

    task automatic test_conflict();
        do_req(16'h0904, -1);
        do_req(16'h0104, -1);
    endtask

    task automatic test_flush();
        do_req(16'h0200, 2);
        do_req(16'h0200, -1);
        do_req(16'h0202, 0);
        do_req(16'h0206, -1);
    endtask

    task automatic test_misaligned();
        logic [15:0] h0;
        logic [15:0] r0;
        h0 = hit_count;
        r0 = req_count;
        do_req(16'h0011, -1);
        n_tests++;
        if (hit_count !== h0 || req_count !== r0) begin
            n_fail++;
            $display("FAIL misaligned_counts: got %h/%h expected %h/%h", hit_count, req_count, h0, r0);
        end
    endtask

    task automatic test_reset_mid_fill();
        int c;
        words_seen = 0;
        req  = 1'b1;
        addr = 16'h0300;
        for (int w = 0; w < 4; w++) maddr_q.push_back({13'h0060, 2'(w), 1'b0});
        c = 0;
        while (words_seen < 2 && c < 40) begin
            @(posedge clk);
            #1;
            c++;
        end
        n_tests++;
        if (words_seen < 2) begin
            n_fail++;
            $display("FAIL mid_fill_words: got %0d words expected 2", words_seen);
        end
        rst = 1'b0;
        req = 1'b0;
        #1;
        n_tests++;
        if (mem_rd !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fill_reset: got mem_rd=%b stall=%b expected 0/0", mem_rd, stall);
        end
        maddr_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_req(16'h0300, -1);
    endtask

    task automatic test_saturation();
        req  = 1'b1;
        addr = 16'h0302;
        repeat (65534) @(posedge clk);
        #1;
        n_tests++;
        if (hit_count !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL hit_count_near_sat: got %h expected fffe", hit_count);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (hit_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL hit_count_sat: got %h expected ffff", hit_count);
        end
        n_tests++;
        if (req_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL req_count_sat: got %h expected ffff", req_count);
        end
        req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss_and_hit();
        test_conflict();
        test_flush();
        test_misaligned();
        test_reset_mid_fill();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
